multicycle_ctrl_fsm: RTL and testbench
======================================

Name: multicycle_ctrl_fsm

Overview:
- Multi-cycle control sequencer for the RV32I-subset datapath.
- Steps each instruction through FETCH/DECODE/EXEC/MEM/WB and handshakes with the unified memory port.
- Drives the immediate-format selects (beq_signal, sw_D_signal) consumed by the immediate sign-extension unit, plus all register-file, ALU, PC and memory enables.
- Tracks retired instructions and flags illegal opcodes and memory timeouts.

Parameters:
- MEM_TIMEOUT, 16, max cycles to wait for mem_ready in any memory-access state before error.
- RETIRE_W, 32, width of retired-instruction counter.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  synchronous, active-high reset.
- mem_rdata  input  32  instruction word from memory, valid when mem_ready=1 in S_FETCH.
- mem_ready  input  1  memory access complete this cycle.
- alu_zero  input  1  ALU zero flag, valid in S_EXEC.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- iord  output  1  0 = address from PC, 1 = address from ALU result.
- ir_write  output  1  latch instruction register.
- pc_write  output  1  update PC.
- pc_src  output  1  0 = PC+4, 1 = branch target.
- reg_write  output  1  register-file write enable.
- mem_to_reg  output  1  writeback source: 1 = memory data, 0 = ALU.
- alu_src  output  1  ALU B operand: 1 = immediate, 0 = rs2.
- alu_op  output  2  00 add, 01 subtract (compare), 10 funct-decoded.
- beq_signal  output  1  select B-type immediate format.
- sw_D_signal  output  1  select S-type immediate format.
- illegal  output  1  sticky illegal-opcode flag.
- bus_err  output  1  sticky memory-timeout flag.
- state  output  3  current state encoding, for debug.
- retired  output  RETIRE_W  count of completed instructions.

Behaviour:
- Reset (synchronous): state=S_FETCH; internal IR=0; illegal=0; bus_err=0; retired=0; timeout counter=0.
  - All request and enable outputs are 0 in the reset cycle.
  - Reset asserted mid-access aborts the access; no partial writes are committed.
- Outputs are decoded from the state register and latched IR only. No combinational path from mem_rdata or alu_zero, except pc_write in S_EXEC for beq.
- Opcodes (IR[6:0]):
  - 0110011 R-type.
  - 0010011 I-type ALU.
  - 0000011 load.
  - 0100011 store.
  - 1100011 branch (funct3=000, beq, only).
  - Anything else is illegal.
- S_FETCH:
  - mem_read=1, iord=0.
  - On mem_ready: ir_write=1, pc_write=1 (pc_src=0), go to S_DECODE.
  - Otherwise stay and increment the timeout counter.
- S_DECODE:
  - beq_signal=1 if branch; sw_D_signal=1 if store.
  - Illegal opcode: set illegal, go to S_HALT.
  - Otherwise go to S_EXEC.
- S_EXEC:
  - R-type: alu_src=0, alu_op=10, go to S_WB.
  - I-type: alu_src=1, alu_op=10, go to S_WB.
  - Load: alu_src=1, alu_op=00, go to S_MEM.
  - Store: alu_src=1, alu_op=00, sw_D_signal=1, go to S_MEM.
  - beq: alu_src=0, alu_op=01, beq_signal=1, pc_src=1, pc_write=alu_zero, retired++, go to S_FETCH.
- S_MEM:
  - iord=1. Load: mem_read=1. Store: mem_write=1, sw_D_signal=1.
  - On mem_ready: load goes to S_WB; store does retired++ and goes to S_FETCH.
  - Otherwise wait, incrementing the timeout counter.
- S_WB:
  - reg_write=1; mem_to_reg=1 for load, else 0.
  - retired++, go to S_FETCH.
- S_HALT:
  - All enables 0. Terminal until reset.
- Timeout:
  - The counter clears on entry to S_FETCH or S_MEM and on mem_ready.
  - If mem_ready is still 0 when the counter reaches MEM_TIMEOUT-1: set bus_err, go to S_HALT, drop mem_read/mem_write the next cycle.
  - mem_ready arriving in that same final cycle wins: the access completes and no error is raised.
- Latency in cycles, with zero memory wait states:
  - R/I-type: 4.
  - Load: 5.
  - Store: 4.
  - beq: 3.
  - Each wait state adds 1.
- retired wraps modulo 2^RETIRE_W.
- Branch (pc_write) and retire occur in the same cycle for beq.
- beq_signal and sw_D_signal are never both 1. Neither is asserted outside the states listed above.
- State encoding: S_FETCH=0, S_DECODE=1, S_EXEC=2, S_MEM=3, S_WB=4, S_HALT=7.

Decomposition:
- Shared package ctrl_pkg:
  - State encodings.
  - Opcode constants (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH).
  - alu_op constants.
- One natural sub-module: ctrl_mem_timeout, the timeout counter.
  - Inputs: clear, count enable.
  - Output: expired.
- The FSM and output decode stay in the top module.

Test Plan:
- Reset, then mem_rdata=0x002081B3 (add x3,x1,x2) with mem_ready=1 on the first FETCH cycle → states 0,1,2,4. ir_write and pc_write=1 in cycle 0; reg_write=1 in cycle 3; retired=1.
- Load 0x0000A183 with 2 memory wait states in S_MEM → S_MEM held 3 cycles with mem_read=1 and iord=1; mem_to_reg=1 and reg_write=1 in S_WB; total 7 cycles.
- Store 0x0020A223 → sw_D_signal=1 in DECODE/EXEC/MEM; mem_write=1 only in S_MEM; reg_write never 1; retired increments in the S_MEM completion cycle.
- beq 0x00208463, run once with alu_zero=1 and once with alu_zero=0 → pc_write=1 with pc_src=1 in S_EXEC only when alu_zero=1; beq_signal=1 in DECODE/EXEC; back to FETCH after 3 cycles.
- Opcode 0x0000007F → illegal=1 after DECODE, state=7, all enables 0. Stays halted until reset; reset clears illegal and returns to FETCH.
- mem_ready held 0 in FETCH with MEM_TIMEOUT=16 → bus_err=1 after the 16th wait cycle, then S_HALT. Separately, mem_ready=1 in exactly the 16th cycle → normal completion, bus_err=0.

Source files
------------

// File: rtl/multicycle_ctrl_fsm_pkg.sv
// rtl/multicycle_ctrl_fsm_pkg.sv - shared state, opcode and alu_op encodings for the multicycle sequencer
package ctrl_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4,
        S_HALT   = 3'd7
    } state_t;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    localparam logic [1:0] ALU_ADD   = 2'b00;
    localparam logic [1:0] ALU_SUB   = 2'b01;
    localparam logic [1:0] ALU_FUNCT = 2'b10;

    typedef enum logic [2:0] {
        K_R,
        K_I,
        K_LOAD,
        K_STORE,
        K_BEQ,
        K_ILLEGAL
    } ikind_t;

    // Only beq (funct3=000) is supported among branches; other funct3 values are illegal.
    function automatic ikind_t classify(input logic [2:0] funct3, input logic [6:0] opcode);
        ikind_t k;
        k = K_ILLEGAL;
        case (opcode)
            OP_R:      k = K_R;
            OP_I:      k = K_I;
            OP_LOAD:   k = K_LOAD;
            OP_STORE:  k = K_STORE;
            OP_BRANCH: k = (funct3 == 3'b000) ? K_BEQ : K_ILLEGAL;
            default:   k = K_ILLEGAL;
        endcase
        return k;
    endfunction

endpackage

// File: rtl/multicycle_ctrl_fsm_if.sv
// rtl/multicycle_ctrl_fsm_if.sv - unified memory port between sequencer (master) and memory (slave)
interface multicycle_ctrl_fsm_if;
    logic [31:0] mem_rdata;
    logic        mem_ready;
    logic        mem_read;
    logic        mem_write;
    logic        iord;

    modport master (
        input  mem_rdata,
        input  mem_ready,
        output mem_read,
        output mem_write,
        output iord
    );

    modport slave (
        output mem_rdata,
        output mem_ready,
        input  mem_read,
        input  mem_write,
        input  iord
    );
endinterface

// File: rtl/multicycle_ctrl_fsm_timeout.sv
// rtl/multicycle_ctrl_fsm_timeout.sv - wait-cycle counter flagging a memory access that never completes
module ctrl_mem_timeout #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic i_clk,
    input  logic i_clr,
    input  logic i_cnt_en,
    output logic o_expired
);
    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;

    logic [CW-1:0] r_cnt;

    assign o_expired = (r_cnt == CW'(MEM_TIMEOUT - 1));

    // Holds at the final count; the controller leaves the wait state that same cycle.
    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            r_cnt <= '0;
        end else if (i_cnt_en && !o_expired) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/multicycle_ctrl_fsm.sv
// rtl/multicycle_ctrl_fsm.sv - FETCH/DECODE/EXEC/MEM/WB control sequencer with retire count and error flags
module multicycle_ctrl_fsm
    import ctrl_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int RETIRE_W    = 32
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    multicycle_ctrl_fsm_if.master mem,
    input  logic                 i_alu_zero,
    output logic                 o_ir_write,
    output logic                 o_pc_write,
    output logic                 o_pc_src,
    output logic                 o_reg_write,
    output logic                 o_mem_to_reg,
    output logic                 o_alu_src,
    output logic [1:0]           o_alu_op,
    output logic                 o_beq_signal,
    output logic                 o_sw_D_signal,
    output logic                 o_illegal,
    output logic                 o_bus_err,
    output logic [2:0]           o_state,
    output logic [RETIRE_W-1:0]  o_retired
);
    state_t                r_state;
    state_t                w_next;
    logic [31:0]           r_ir;
    logic                  r_illegal;
    logic                  r_bus_err;
    logic [RETIRE_W-1:0]   r_retired;

    ikind_t                w_kind;
    logic                  w_expired;
    logic                  w_cnt_en;
    logic                  w_tmo_clr;
    logic                  w_retire;
    logic                  w_set_ill;
    logic                  w_set_be;
    logic                  w_mem_read;
    logic                  w_mem_write;
    logic                  w_iord;
    logic                  w_unused_ir;

    assign w_kind      = classify(r_ir[14:12], r_ir[6:0]);
    assign w_unused_ir = &{1'b0, r_ir[31:15], r_ir[11:7]};

    assign w_tmo_clr = i_reset || (w_next != r_state) || mem.mem_ready;

    ctrl_mem_timeout #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_clr     (w_tmo_clr),
        .i_cnt_en  (w_cnt_en),
        .o_expired (w_expired)
    );

    always_comb begin
        w_next        = r_state;
        w_cnt_en      = 1'b0;
        w_retire      = 1'b0;
        w_set_ill     = 1'b0;
        w_set_be      = 1'b0;
        w_mem_read    = 1'b0;
        w_mem_write   = 1'b0;
        w_iord        = 1'b0;
        o_ir_write    = 1'b0;
        o_pc_write    = 1'b0;
        o_pc_src      = 1'b0;
        o_reg_write   = 1'b0;
        o_mem_to_reg  = 1'b0;
        o_alu_src     = 1'b0;
        o_alu_op      = ALU_ADD;
        o_beq_signal  = 1'b0;
        o_sw_D_signal = 1'b0;

        case (r_state)
            S_FETCH: begin
                w_mem_read = 1'b1;
                if (mem.mem_ready) begin
                    o_ir_write = 1'b1;
                    o_pc_write = 1'b1;
                    w_next     = S_DECODE;
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_expired) begin
                        w_set_be = 1'b1;
                        w_next   = S_HALT;
                    end
                end
            end
            S_DECODE: begin
                o_beq_signal  = (w_kind == K_BEQ);
                o_sw_D_signal = (w_kind == K_STORE);
                if (w_kind == K_ILLEGAL) begin
                    w_set_ill = 1'b1;
                    w_next    = S_HALT;
                end else begin
                    w_next = S_EXEC;
                end
            end
            S_EXEC: begin
                case (w_kind)
                    K_R: begin
                        o_alu_op = ALU_FUNCT;
                        w_next   = S_WB;
                    end
                    K_I: begin
                        o_alu_src = 1'b1;
                        o_alu_op  = ALU_FUNCT;
                        w_next    = S_WB;
                    end
                    K_LOAD: begin
                        o_alu_src = 1'b1;
                        w_next    = S_MEM;
                    end
                    K_STORE: begin
                        o_alu_src     = 1'b1;
                        o_sw_D_signal = 1'b1;
                        w_next        = S_MEM;
                    end
                    K_BEQ: begin
                        o_alu_op     = ALU_SUB;
                        o_beq_signal = 1'b1;
                        o_pc_src     = 1'b1;
                        o_pc_write   = i_alu_zero;
                        w_retire     = 1'b1;
                        w_next       = S_FETCH;
                    end
                    default: w_next = S_HALT;
                endcase
            end
            S_MEM: begin
                w_iord        = 1'b1;
                w_mem_read    = (w_kind == K_LOAD);
                w_mem_write   = (w_kind == K_STORE);
                o_sw_D_signal = (w_kind == K_STORE);
                if (mem.mem_ready) begin
                    if (w_kind == K_LOAD) begin
                        w_next = S_WB;
                    end else begin
                        w_retire = 1'b1;
                        w_next   = S_FETCH;
                    end
                end else begin
                    w_cnt_en = 1'b1;
                    if (w_expired) begin
                        w_set_be = 1'b1;
                        w_next   = S_HALT;
                    end
                end
            end
            S_WB: begin
                o_reg_write  = 1'b1;
                o_mem_to_reg = (w_kind == K_LOAD);
                w_retire     = 1'b1;
                w_next       = S_FETCH;
            end
            S_HALT: w_next = S_HALT;
            default: w_next = S_HALT;
        endcase

        // Reset aborts whatever the state register holds: nothing may be requested or committed.
        if (i_reset) begin
            w_mem_read    = 1'b0;
            w_mem_write   = 1'b0;
            w_iord        = 1'b0;
            o_ir_write    = 1'b0;
            o_pc_write    = 1'b0;
            o_pc_src      = 1'b0;
            o_reg_write   = 1'b0;
            o_mem_to_reg  = 1'b0;
            o_alu_src     = 1'b0;
            o_alu_op      = ALU_ADD;
            o_beq_signal  = 1'b0;
            o_sw_D_signal = 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= S_FETCH;
            r_ir      <= '0;
            r_illegal <= 1'b0;
            r_bus_err <= 1'b0;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (o_ir_write) begin
                r_ir <= mem.mem_rdata;
            end
            if (w_set_ill) begin
                r_illegal <= 1'b1;
            end
            if (w_set_be) begin
                r_bus_err <= 1'b1;
            end
            if (w_retire) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    assign mem.mem_read  = w_mem_read;
    assign mem.mem_write = w_mem_write;
    assign mem.iord      = w_iord;
    assign o_illegal     = r_illegal;
    assign o_bus_err     = r_bus_err;
    assign o_state       = r_state;
    assign o_retired     = r_retired;
endmodule

// File: tb/tb_multicycle_ctrl_fsm.sv
// tb/tb_multicycle_ctrl_fsm.sv - randomized instruction stream checked cycle by cycle against a per-instruction model
module tb_multicycle_ctrl_fsm;
    localparam int RW  = 6;
    localparam int TMO = 16;

    localparam int K_R = 0, K_I = 1, K_LD = 2, K_ST = 3, K_BEQ = 4, K_ILL = 5;

    localparam logic [12:0] C_MR  = 13'h1000;
    localparam logic [12:0] C_MW  = 13'h0800;
    localparam logic [12:0] C_IO  = 13'h0400;
    localparam logic [12:0] C_IRW = 13'h0200;
    localparam logic [12:0] C_PCW = 13'h0100;
    localparam logic [12:0] C_PCS = 13'h0080;
    localparam logic [12:0] C_RW  = 13'h0040;
    localparam logic [12:0] C_M2R = 13'h0020;
    localparam logic [12:0] C_AS  = 13'h0010;
    localparam logic [12:0] C_FN  = 13'h0008;
    localparam logic [12:0] C_SUB = 13'h0004;
    localparam logic [12:0] C_BQ  = 13'h0002;
    localparam logic [12:0] C_SW  = 13'h0001;
    localparam logic [12:0] C_NONE = 13'h0000;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          alu_zero = 1'b0;
    logic          ir_write, pc_write, pc_src, reg_write, mem_to_reg, alu_src;
    logic [1:0]    alu_op;
    logic          beq_signal, sw_D_signal, illegal, bus_err;
    logic [2:0]    state;
    logic [RW-1:0] retired;

    always #5 clk = ~clk;

    multicycle_ctrl_fsm_if mif ();

    multicycle_ctrl_fsm #(
        .MEM_TIMEOUT (TMO),
        .RETIRE_W    (RW)
    ) dut (
        .i_clk         (clk),
        .i_reset       (reset),
        .mem           (mif),
        .i_alu_zero    (alu_zero),
        .o_ir_write    (ir_write),
        .o_pc_write    (pc_write),
        .o_pc_src      (pc_src),
        .o_reg_write   (reg_write),
        .o_mem_to_reg  (mem_to_reg),
        .o_alu_src     (alu_src),
        .o_alu_op      (alu_op),
        .o_beq_signal  (beq_signal),
        .o_sw_D_signal (sw_D_signal),
        .o_illegal     (illegal),
        .o_bus_err     (bus_err),
        .o_state       (state),
        .o_retired     (retired)
    );

    typedef struct {
        logic          rst;
        logic          rdy;
        logic          z;
        logic [31:0]   rd;
        logic [17:0]   exp;
        logic [RW-1:0] ret;
    } cyc_t;

    cyc_t q[$];

    int n_tests = 0;
    int n_fail  = 0;

    logic [2:0] m_st;
    logic       m_il;
    logic       m_be;
    int         m_ret;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, want %h", tag, obs, exp);
        end
    endtask

    function automatic logic rb();
        return 1'($urandom());
    endfunction

    task automatic push(input logic rst, input logic rdy, input logic z, input logic [31:0] rd,
                        input logic [2:0] st, input logic [12:0] ctl);
        cyc_t c;
        c.rst = rst;
        c.rdy = rdy;
        c.z   = z;
        c.rd  = rd;
        c.exp = {st, ctl, m_il, m_be};
        c.ret = RW'(m_ret);
        q.push_back(c);
    endtask

    task automatic gen_reset();
        push(1'b1, rb(), rb(), $urandom(), m_st, C_NONE);
        m_il  = 1'b0;
        m_be  = 1'b0;
        m_ret = 0;
        m_st  = 3'd0;
    endtask

    task automatic gen_halt(input int n);
        for (int i = 0; i < n; i++) push(1'b0, rb(), rb(), $urandom(), 3'd7, C_NONE);
    endtask

    function automatic logic [31:0] rand_word(input int kind);
        logic [31:0] w;
        logic [6:0]  op;
        w = $urandom();
        case (kind)
            K_R:   w[6:0] = 7'b0110011;
            K_I:   w[6:0] = 7'b0010011;
            K_LD:  w[6:0] = 7'b0000011;
            K_ST:  w[6:0] = 7'b0100011;
            K_BEQ: begin
                w[6:0]   = 7'b1100011;
                w[14:12] = 3'b000;
            end
            default: begin
                if (rb()) begin
                    w[6:0]   = 7'b1100011;
                    w[14:12] = 3'($urandom_range(7, 1));
                end else begin
                    do op = 7'($urandom());
                    while (op == 7'b0110011 || op == 7'b0010011 || op == 7'b0000011 ||
                           op == 7'b0100011 || op == 7'b1100011);
                    w[6:0] = op;
                end
            end
        endcase
        return w;
    endfunction

    // One instruction: fw/mw are memory wait cycles before mem_ready in fetch/memory access.
    task automatic gen_instr(input int kind, input logic [31:0] w, input int fw, input int mw,
                             input logic z, input bit abort);
        logic [12:0] mc;
        bit          ld;
        ld = (kind == K_LD);
        for (int i = 0; i < fw && i < TMO; i++) push(1'b0, 1'b0, rb(), $urandom(), 3'd0, C_MR);
        if (fw >= TMO) begin
            m_be = 1'b1;
            m_st = 3'd7;
            return;
        end
        push(1'b0, 1'b1, rb(), w, 3'd0, C_MR | C_IRW | C_PCW);
        push(1'b0, rb(), rb(), $urandom(), 3'd1,
             ((kind == K_BEQ) ? C_BQ : C_NONE) | ((kind == K_ST) ? C_SW : C_NONE));
        if (kind == K_ILL) begin
            m_il = 1'b1;
            m_st = 3'd7;
            return;
        end
        case (kind)
            K_R:  push(1'b0, rb(), rb(), $urandom(), 3'd2, C_FN);
            K_I:  push(1'b0, rb(), rb(), $urandom(), 3'd2, C_AS | C_FN);
            K_LD: push(1'b0, rb(), rb(), $urandom(), 3'd2, C_AS);
            K_ST: push(1'b0, rb(), rb(), $urandom(), 3'd2, C_AS | C_SW);
            default: begin
                push(1'b0, rb(), z, $urandom(), 3'd2, C_SUB | C_BQ | C_PCS | (z ? C_PCW : C_NONE));
                m_ret++;
                return;
            end
        endcase
        if (kind == K_LD || kind == K_ST) begin
            mc = C_IO | (ld ? C_MR : (C_MW | C_SW));
            for (int i = 0; i < mw && i < TMO; i++) begin
                push(1'b0, 1'b0, rb(), $urandom(), 3'd3, mc);
                if (abort) begin
                    m_st = 3'd3;
                    gen_reset();
                    return;
                end
            end
            if (mw >= TMO) begin
                m_be = 1'b1;
                m_st = 3'd7;
                return;
            end
            push(1'b0, 1'b1, rb(), $urandom(), 3'd3, mc);
            if (!ld) begin
                m_ret++;
                return;
            end
        end
        push(1'b0, rb(), rb(), $urandom(), 3'd4, C_RW | (ld ? C_M2R : C_NONE));
        m_ret++;
    endtask

    task automatic settle_halt();
        if (m_st == 3'd7) begin
            gen_halt(3);
            gen_reset();
        end
    endtask

    task automatic play();
        cyc_t        c;
        logic [17:0] obs;
        int          cyc;
        cyc = 0;
        while (q.size() > 0) begin
            c = q.pop_front();
            @(negedge clk);
            reset          = c.rst;
            mif.mem_ready  = c.rdy;
            mif.mem_rdata  = c.rd;
            alu_zero       = c.z;
            #1;
            obs = {state, mif.mem_read, mif.mem_write, mif.iord, ir_write, pc_write, pc_src,
                   reg_write, mem_to_reg, alu_src, alu_op, beq_signal, sw_D_signal, illegal, bus_err};
            chk($sformatf("ctl@%0d", cyc), 32'(obs), 32'(c.exp));
            chk($sformatf("retired@%0d", cyc), 32'(retired), 32'(c.ret));
            cyc++;
        end
    endtask

    initial begin
        int kind, fw, mw, r;
        bit ab;
        mif.mem_ready = 1'b0;
        mif.mem_rdata = 32'h0;
        reset = 1'b1;
        m_st  = 3'd0;
        m_il  = 1'b0;
        m_be  = 1'b0;
        m_ret = 0;
        @(posedge clk);

        gen_reset();
        gen_instr(K_R,   32'h002081B3, 0, 0, 1'b0, 1'b0);
        gen_instr(K_LD,  32'h0000A183, 0, 2, 1'b0, 1'b0);
        gen_instr(K_ST,  32'h0020A223, 0, 0, 1'b0, 1'b0);
        gen_instr(K_BEQ, 32'h00208463, 0, 0, 1'b1, 1'b0);
        gen_instr(K_BEQ, 32'h00208463, 0, 0, 1'b0, 1'b0);
        gen_instr(K_ILL, 32'h0000007F, 0, 0, 1'b0, 1'b0);
        settle_halt();
        gen_instr(K_R,  rand_word(K_R),  TMO,     0, 1'b0, 1'b0);
        settle_halt();
        gen_instr(K_I,  rand_word(K_I),  TMO - 1, 0, 1'b0, 1'b0);
        gen_instr(K_LD, rand_word(K_LD), 1, TMO, 1'b0, 1'b0);
        settle_halt();
        gen_instr(K_ST, rand_word(K_ST), 0, TMO - 1, 1'b0, 1'b0);
        gen_instr(K_LD, rand_word(K_LD), 0, 2, 1'b0, 1'b1);

        for (int n = 0; n < 220; n++) begin
            kind = $urandom_range(11, 0);
            if (kind > K_ILL) kind = $urandom_range(K_BEQ, K_R);
            r  = $urandom_range(19, 0);
            fw = (r == 0) ? $urandom_range(TMO, TMO - 2) : $urandom_range(2, 0);
            r  = $urandom_range(19, 0);
            mw = (r == 0) ? $urandom_range(TMO, TMO - 2) : $urandom_range(3, 0);
            ab = ($urandom_range(29, 0) == 0) && (mw > 0) && (mw < TMO);
            gen_instr(kind, rand_word(kind), fw, mw, rb(), ab);
            settle_halt();
        end

        play();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
